avalon_bram_burst: RTL and testbench
====================================

// Module: avalon_bram_burst
// PURPOSE
//  Parametrised Avalon-MM agent on-chip RAM. Data width, depth, read latency and burst
//  addressing mode are set by parameters; supports pipelined burst reads and burst writes
//  with per-byte enables. Sits behind the Avalon interconnect as a generic scratch/frame memory.
// PARAMETERS
//  DATA_W        32   data bus width in bits; 32, 64 or 128; BE_W = DATA_W/8
//  RAM_ADD_W     8    log2 of memory depth in DATA_W words
//  ADDR_W        32   width of the Avalon byte address
//  BURSTCOUNT_W  4    width of burstcount; legal bursts 1..2**BURSTCOUNT_W-1
//  READ_LATENCY  1    cycles from read acceptance to first readdatavalid; 1 or 2
//  WRAP_BURST    0    0 = incrementing bursts, 1 = wrapping bursts
// PORTS
//  clk            in   1             clock, all logic on rising edge
//  reset_n        in   1             asynchronous active-low reset
//  address        in   ADDR_W        byte address of the first beat
//  read           in   1             read request
//  write          in   1             write request, one beat per accepted cycle
//  burstcount     in   BURSTCOUNT_W  beats in the burst, sampled on the first accepted beat
//  byteenable     in   BE_W          per-byte write enable for the current beat
//  writedata      in   DATA_W        write beat data
//  waitrequest    out  1             1 = agent not accepting a command/beat this cycle
//  readdata       out  DATA_W        read beat data, 0 when readdatavalid=0
//  readdatavalid  out  1             readdata holds a valid beat
// BEHAVIOUR
//  Reset (reset_n=0, async): waitrequest=1, readdatavalid=0, readdata=0, FSM=IDLE, counters=0.
//   Pending read beats are discarded. Memory array is not cleared. waitrequest stays 1 for the
//   first clk edge after reset_n rises and is 0 from the following cycle.
//  Word index = address >> log2(BE_W), truncated to RAM_ADD_W bits. Low byte-offset bits are
//   ignored. Beat addresses wrap modulo 2**RAM_ADD_W.
//  burstcount=0 is treated as 1.
//  FSM states: IDLE, WR_BURST, RD_BURST.
//  IDLE: waitrequest=0.
//   write=1: beat 0 is written at base. If N>1, go to WR_BURST with N-1 beats left; else stay IDLE.
//   read=1 (write=0): latch base and N, go to RD_BURST.
//   read=1 and write=1 together: write wins and the read is dropped.
//  WR_BURST: waitrequest=0. Each cycle with write=1 writes the next beat.
//   write=0 inserts an idle cycle, with no timeout. read is ignored.
//   Return to IDLE on the edge that accepts the last beat.
//   Only bytes with byteenable=1 are modified.
//  RD_BURST: waitrequest=1. Read at acceptance edge T, burst of N beats:
//   - beat k (k=0..N-1) has readdatavalid=1 in cycle T+READ_LATENCY+k, with no gaps.
//   - waitrequest=0 again in cycle T+READ_LATENCY+N. A new command is accepted there.
//  Beat address for beat k, base word B:
//   - WRAP_BURST=0: B+k.
//   - WRAP_BURST=1 and N a power of two: (B & ~(N-1)) | ((B+k) & (N-1)).
//   - WRAP_BURST=1 and N not a power of two: incrementing.
//  readdata is registered. READ_LATENCY=2 adds one output register stage.
//  A reset assertion mid-burst aborts it immediately. No further readdatavalid. Partial writes
//   already committed remain.
// TESTING
//  - Reset: hold reset_n=0 for 3 clk -> waitrequest=1, readdatavalid=0. After release, waitrequest=0
//    from the 2nd cycle.
//  - Single write then read: write 0xDEADBEEF @0x10, BE=4'hF, then read @0x10, N=1, LAT=1.
//    Expect readdatavalid one cycle after accept, readdata=0xDEADBEEF, waitrequest 0 the cycle after.
//  - Byte enables: write 0x11223344 @0, then 0xAABBCCDD with BE=4'b0101.
//    Read -> 0x11BB33DD.
//  - Incrementing burst: write N=4 words 1,2,3,4 @word 254 (RAM_ADD_W=8) with a write=0 gap
//    after beat 1. Read N=4 @254 -> 1,2,3,4 on consecutive cycles. Words 0 and 1 hold 3 and 4.
//  - Wrapping burst: WRAP_BURST=1, fill words 0..3 with A,B,C,D. Read N=4 @word 2 -> C,D,A,B.
//  - Reset mid-read: LAT=2, N=8 read, pull reset_n low after beat 2 -> readdatavalid=0 at once,
//    no further beats. After release, a single read returns the correct stored data.
//  - DATA_W=128, BE_W=16: write with BE=16'h00FF, then read -> upper 64 bits unchanged.
//  - Read + write together in IDLE: write lands, no readdatavalid follows.

Source files
------------

// File: rtl/avalon_bram_burst.sv
// Avalon-MM agent on-chip RAM with pipelined burst reads and byte-enabled burst writes.
// Supports incrementing or wrapping burst addressing and a read latency of 1 or 2.
module avalon_bram_burst #(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned RAM_ADD_W    = 8,
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned BURSTCOUNT_W = 4,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned WRAP_BURST   = 0
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [ADDR_W-1:0]       address,
    input  logic                    read,
    input  logic                    write,
    input  logic [BURSTCOUNT_W-1:0] burstcount,
    input  logic [DATA_W/8-1:0]     byteenable,
    input  logic [DATA_W-1:0]       writedata,
    output logic                    waitrequest,
    output logic [DATA_W-1:0]       readdata,
    output logic                    readdatavalid
);
    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned OFF_W = $clog2(BE_W);
    localparam int unsigned DEPTH = 2 ** RAM_ADD_W;

    typedef logic [BURSTCOUNT_W:0] cnt_t;
    localparam cnt_t ONE = cnt_t'(1);

    typedef enum logic [1:0] {IDLE, WR_BURST, RD_BURST} state_t;

    state_t                  state;
    logic [RAM_ADD_W-1:0]    base;
    logic [BURSTCOUNT_W-1:0] n;
    cnt_t                    beat;
    logic                    v1, v2;
    logic [DATA_W-1:0]       rd1, rd2;
    logic [DATA_W-1:0]       mem [DEPTH];

    logic [RAM_ADD_W-1:0]    addr_word;
    logic [RAM_ADD_W-1:0]    mem_addr;
    logic [BURSTCOUNT_W-1:0] n_in;
    cnt_t                    rd_end;
    logic                    we;
    logic                    unused_addr;

    function automatic logic [RAM_ADD_W-1:0] beat_addr(
        input logic [RAM_ADD_W-1:0]    b,
        input cnt_t                    k,
        input logic [BURSTCOUNT_W-1:0] cnt
    );
        logic [RAM_ADD_W-1:0] mask;
        logic [RAM_ADD_W-1:0] inc;
        mask = RAM_ADD_W'(cnt) - RAM_ADD_W'(1);
        inc  = b + RAM_ADD_W'(k);
        if (WRAP_BURST != 0 && (cnt & (cnt - BURSTCOUNT_W'(1))) == '0)
            return (b & ~mask) | (inc & mask);
        return inc;
    endfunction

    assign unused_addr = ^address;
    assign addr_word   = address[OFF_W +: RAM_ADD_W];
    assign n_in        = (burstcount == '0) ? BURSTCOUNT_W'(1) : burstcount;
    // Last RD_BURST edge: all beats issued plus the extra output stage when latency is 2.
    assign rd_end      = {1'b0, n} + cnt_t'(READ_LATENCY - 1);
    assign mem_addr    = (state == IDLE) ? addr_word : beat_addr(base, beat, n);
    assign we          = write && !waitrequest && (state != RD_BURST);

    always_ff @(posedge clk) begin
        if (we) begin
            for (int unsigned i = 0; i < BE_W; i++) begin
                if (byteenable[i]) mem[mem_addr][8*i +: 8] <= writedata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            waitrequest <= 1'b1;
            base        <= '0;
            n           <= '0;
            beat        <= '0;
            v1          <= 1'b0;
            v2          <= 1'b0;
            rd1         <= '0;
            rd2         <= '0;
        end else begin
            v1  <= 1'b0;
            rd1 <= '0;
            v2  <= v1;
            rd2 <= rd1;
            case (state)
                IDLE: begin
                    waitrequest <= 1'b0;
                    if (!waitrequest) begin
                        if (write) begin
                            if (n_in > BURSTCOUNT_W'(1)) begin
                                state <= WR_BURST;
                                base  <= addr_word;
                                n     <= n_in;
                                beat  <= ONE;
                            end
                        end else if (read) begin
                            state       <= RD_BURST;
                            waitrequest <= 1'b1;
                            base        <= addr_word;
                            n           <= n_in;
                            beat        <= ONE;
                            v1          <= 1'b1;
                            rd1         <= mem[mem_addr];
                        end
                    end
                end
                WR_BURST: begin
                    if (write) begin
                        beat <= beat + ONE;
                        if (beat == {1'b0, n} - ONE) state <= IDLE;
                    end
                end
                RD_BURST: begin
                    if (beat < {1'b0, n}) begin
                        v1  <= 1'b1;
                        rd1 <= mem[mem_addr];
                    end
                    beat <= beat + ONE;
                    if (beat == rd_end) begin
                        state       <= IDLE;
                        waitrequest <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign readdatavalid = (READ_LATENCY == 2) ? v2 : v1;
    assign readdata      = (READ_LATENCY == 2) ? rd2 : rd1;

endmodule

// File: tb/tb_avalon_bram_burst.sv
// Directed bench for avalon_bram_burst: default, wrapping, latency-2 and 128-bit instances.
module tb_avalon_bram_burst;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    // Instances 0..2 are 32-bit: 0 default, 1 wrapping, 2 read latency 2.
    logic [31:0] address [3];
    logic        rd      [3];
    logic        wr      [3];
    logic [3:0]  bc      [3];
    logic [3:0]  be      [3];
    logic [31:0] wd      [3];
    logic        wreq    [3];
    logic [31:0] rdata   [3];
    logic        rvalid  [3];

    logic [31:0]  a3;
    logic         rd3, wr3, wreq3, rvalid3;
    logic [3:0]   bc3;
    logic [15:0]  be3;
    logic [127:0] wd3, rdata3;

    int compared = 0;
    int mismatched = 0;

    logic [31:0] got_data [16];
    int          got_cyc  [16];
    int          got_cnt;
    int          got_wlow;

    avalon_bram_burst u0 (
        .clk(clk), .reset_n(reset_n), .address(address[0]), .read(rd[0]), .write(wr[0]),
        .burstcount(bc[0]), .byteenable(be[0]), .writedata(wd[0]), .waitrequest(wreq[0]),
        .readdata(rdata[0]), .readdatavalid(rvalid[0])
    );
    avalon_bram_burst #(.WRAP_BURST(1)) u1 (
        .clk(clk), .reset_n(reset_n), .address(address[1]), .read(rd[1]), .write(wr[1]),
        .burstcount(bc[1]), .byteenable(be[1]), .writedata(wd[1]), .waitrequest(wreq[1]),
        .readdata(rdata[1]), .readdatavalid(rvalid[1])
    );
    avalon_bram_burst #(.READ_LATENCY(2)) u2 (
        .clk(clk), .reset_n(reset_n), .address(address[2]), .read(rd[2]), .write(wr[2]),
        .burstcount(bc[2]), .byteenable(be[2]), .writedata(wd[2]), .waitrequest(wreq[2]),
        .readdata(rdata[2]), .readdatavalid(rvalid[2])
    );
    avalon_bram_burst #(.DATA_W(128)) u3 (
        .clk(clk), .reset_n(reset_n), .address(a3), .read(rd3), .write(wr3),
        .burstcount(bc3), .byteenable(be3), .writedata(wd3), .waitrequest(wreq3),
        .readdata(rdata3), .readdatavalid(rvalid3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_beat(input int d, input logic [31:0] a, input logic [3:0] n,
                              input logic [31:0] data, input logic [3:0] bytes);
        address[d] = a;
        bc[d]      = n;
        wd[d]      = data;
        be[d]      = bytes;
        wr[d]      = 1'b1;
        tick();
        wr[d]      = 1'b0;
    endtask

    // Issues one read and collects beats until waitrequest drops; cycle 1 is the one after acceptance.
    task automatic read_burst(input int d, input logic [31:0] a, input logic [3:0] n);
        address[d] = a;
        bc[d]      = n;
        rd[d]      = 1'b1;
        tick();
        rd[d]      = 1'b0;
        got_cnt    = 0;
        got_wlow   = -1;
        for (int i = 1; i <= 40; i++) begin
            if (rvalid[d]) begin
                if (got_cnt < 16) begin
                    got_data[got_cnt] = rdata[d];
                    got_cyc[got_cnt]  = i;
                end
                got_cnt++;
            end
            if (!wreq[d]) begin
                got_wlow = i;
                break;
            end
            tick();
        end
        compared++;
        if (got_wlow < 0) begin
            $display("FAIL read_timeout dut%0d: waitrequest never returned to 0 within 40 cycles", d);
            mismatched++;
        end
    endtask

    task automatic test_reset();
        repeat (3) tick();
        compared += 4;
        if (wreq[0] !== 1'b1) begin $display("FAIL reset_wreq: got %b want 1", wreq[0]); mismatched++; end
        if (rvalid[0] !== 1'b0) begin $display("FAIL reset_rvalid: got %b want 0", rvalid[0]); mismatched++; end
        if (rdata[0] !== 32'h0) begin $display("FAIL reset_rdata: got %h want 0", rdata[0]); mismatched++; end
        if (wreq3 !== 1'b1) begin $display("FAIL reset_wreq_w128: got %b want 1", wreq3); mismatched++; end
        reset_n = 1'b1;
        #1;
        compared++;
        if (wreq[0] !== 1'b1) begin $display("FAIL release_wreq_c1: got %b want 1", wreq[0]); mismatched++; end
        tick();
        compared++;
        if (wreq[0] !== 1'b0) begin $display("FAIL release_wreq_c2: got %b want 0", wreq[0]); mismatched++; end
    endtask

    task automatic test_single();
        write_beat(0, 32'h10, 4'd1, 32'hDEADBEEF, 4'hF);
        read_burst(0, 32'h10, 4'd1);
        compared += 5;
        if (got_cnt !== 1) begin $display("FAIL single_count: got %0d want 1", got_cnt); mismatched++; end
        if (got_data[0] !== 32'hDEADBEEF) begin $display("FAIL single_data: got %h want deadbeef", got_data[0]); mismatched++; end
        if (got_cyc[0] !== 1) begin $display("FAIL single_latency: got %0d want 1", got_cyc[0]); mismatched++; end
        if (got_wlow !== 2) begin $display("FAIL single_wreq_low: got %0d want 2", got_wlow); mismatched++; end
        if (rdata[0] !== 32'h0) begin $display("FAIL single_rdata_idle: got %h want 0", rdata[0]); mismatched++; end
        read_burst(0, 32'h13, 4'd0);
        compared += 2;
        if (got_cnt !== 1) begin $display("FAIL bc0_count: got %0d want 1", got_cnt); mismatched++; end
        if (got_data[0] !== 32'hDEADBEEF) begin $display("FAIL bc0_data: got %h want deadbeef", got_data[0]); mismatched++; end
    endtask

    task automatic test_byte_enables();
        write_beat(0, 32'h0, 4'd1, 32'h11223344, 4'hF);
        write_beat(0, 32'h0, 4'd1, 32'hAABBCCDD, 4'b0101);
        read_burst(0, 32'h0, 4'd1);
        compared++;
        if (got_data[0] !== 32'h11BB33DD) begin $display("FAIL byte_enable: got %h want 11bb33dd", got_data[0]); mismatched++; end
    endtask

    task automatic test_incr_burst();
        write_beat(0, 32'h3F8, 4'd4, 32'd1, 4'hF);
        write_beat(0, 32'h3F8, 4'd4, 32'd2, 4'hF);
        tick();
        write_beat(0, 32'h3F8, 4'd4, 32'd3, 4'hF);
        write_beat(0, 32'h3F8, 4'd4, 32'd4, 4'hF);
        compared++;
        if (wreq[0] !== 1'b0) begin $display("FAIL incr_wr_wreq: got %b want 0", wreq[0]); mismatched++; end
        read_burst(0, 32'h3F8, 4'd4);
        compared += 2;
        if (got_cnt !== 4) begin $display("FAIL incr_count: got %0d want 4", got_cnt); mismatched++; end
        if (got_wlow !== 5) begin $display("FAIL incr_wreq_low: got %0d want 5", got_wlow); mismatched++; end
        for (int k = 0; k < 4; k++) begin
            compared += 2;
            if (got_data[k] !== 32'(k + 1)) begin $display("FAIL incr_data%0d: got %h want %h", k, got_data[k], k + 1); mismatched++; end
            if (got_cyc[k] !== k + 1) begin $display("FAIL incr_cycle%0d: got %0d want %0d", k, got_cyc[k], k + 1); mismatched++; end
        end
        read_burst(0, 32'h0, 4'd2);
        compared += 2;
        if (got_data[0] !== 32'd3) begin $display("FAIL incr_wrap_w0: got %h want 3", got_data[0]); mismatched++; end
        if (got_data[1] !== 32'd4) begin $display("FAIL incr_wrap_w1: got %h want 4", got_data[1]); mismatched++; end
    endtask

    task automatic test_back_to_back();
        read_burst(0, 32'h3F8, 4'd2);
        read_burst(0, 32'h10, 4'd1);
        compared += 2;
        if (got_cyc[0] !== 1) begin $display("FAIL b2b_latency: got %0d want 1", got_cyc[0]); mismatched++; end
        if (got_data[0] !== 32'hDEADBEEF) begin $display("FAIL b2b_data: got %h want deadbeef", got_data[0]); mismatched++; end
    endtask

    task automatic test_wrap();
        logic [31:0] exp4 [4];
        logic [31:0] exp3 [3];
        exp4 = '{32'hC, 32'hD, 32'hA, 32'hB};
        exp3 = '{32'hC, 32'hD, 32'hE};
        for (int k = 0; k < 5; k++) write_beat(1, 32'h0, 4'd5, 32'(10 + k), 4'hF);
        read_burst(1, 32'h8, 4'd4);
        compared++;
        if (got_cnt !== 4) begin $display("FAIL wrap_count: got %0d want 4", got_cnt); mismatched++; end
        for (int k = 0; k < 4; k++) begin
            compared++;
            if (got_data[k] !== exp4[k]) begin $display("FAIL wrap_data%0d: got %h want %h", k, got_data[k], exp4[k]); mismatched++; end
        end
        read_burst(1, 32'h8, 4'd3);
        for (int k = 0; k < 3; k++) begin
            compared++;
            if (got_data[k] !== exp3[k]) begin $display("FAIL wrap_npow2_data%0d: got %h want %h", k, got_data[k], exp3[k]); mismatched++; end
        end
    endtask

    task automatic test_reset_mid_read();
        int stray;
        for (int k = 0; k < 8; k++) write_beat(2, 32'h0, 4'd8, 32'h100 + 32'(k), 4'hF);
        address[2] = 32'h0;
        bc[2]      = 4'd8;
        rd[2]      = 1'b1;
        tick();
        rd[2]      = 1'b0;
        compared++;
        if (rvalid[2] !== 1'b0) begin $display("FAIL lat2_c1_rvalid: got %b want 0", rvalid[2]); mismatched++; end
        tick();
        compared += 2;
        if (rvalid[2] !== 1'b1) begin $display("FAIL lat2_c2_rvalid: got %b want 1", rvalid[2]); mismatched++; end
        if (rdata[2] !== 32'h100) begin $display("FAIL lat2_beat0: got %h want 100", rdata[2]); mismatched++; end
        tick();
        tick();
        compared++;
        if (rdata[2] !== 32'h102) begin $display("FAIL lat2_beat2: got %h want 102", rdata[2]); mismatched++; end
        reset_n = 1'b0;
        #1;
        compared += 3;
        if (rvalid[2] !== 1'b0) begin $display("FAIL abort_rvalid: got %b want 0", rvalid[2]); mismatched++; end
        if (rdata[2] !== 32'h0) begin $display("FAIL abort_rdata: got %h want 0", rdata[2]); mismatched++; end
        if (wreq[2] !== 1'b1) begin $display("FAIL abort_wreq: got %b want 1", wreq[2]); mismatched++; end
        stray = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (rvalid[2]) stray++;
        end
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (rvalid[2]) stray++;
        end
        compared++;
        if (stray !== 0) begin $display("FAIL abort_stray_beats: got %0d want 0", stray); mismatched++; end
        read_burst(2, 32'h14, 4'd1);
        compared += 4;
        if (got_cnt !== 1) begin $display("FAIL post_reset_count: got %0d want 1", got_cnt); mismatched++; end
        if (got_data[0] !== 32'h105) begin $display("FAIL post_reset_data: got %h want 105", got_data[0]); mismatched++; end
        if (got_cyc[0] !== 2) begin $display("FAIL post_reset_latency: got %0d want 2", got_cyc[0]); mismatched++; end
        if (got_wlow !== 3) begin $display("FAIL post_reset_wreq_low: got %0d want 3", got_wlow); mismatched++; end
    endtask

    task automatic test_wide();
        a3  = 32'h20;
        bc3 = 4'd1;
        wd3 = 128'h0123456789ABCDEF_FEDCBA9876543210;
        be3 = 16'hFFFF;
        wr3 = 1'b1;
        tick();
        wd3 = 128'h5555555555555555_5555555555555555;
        be3 = 16'h00FF;
        tick();
        wr3 = 1'b0;
        rd3 = 1'b1;
        tick();
        rd3 = 1'b0;
        compared += 2;
        if (rvalid3 !== 1'b1) begin $display("FAIL wide_rvalid: got %b want 1", rvalid3); mismatched++; end
        if (rdata3 !== 128'h0123456789ABCDEF_5555555555555555) begin
            $display("FAIL wide_data: got %h want 0123456789abcdef5555555555555555", rdata3); mismatched++;
        end
        tick();
        compared++;
        if (wreq3 !== 1'b0) begin $display("FAIL wide_wreq_low: got %b want 0", wreq3); mismatched++; end
    endtask

    task automatic test_read_write_together();
        int stray;
        address[0] = 32'h40;
        bc[0]      = 4'd1;
        wd[0]      = 32'hCAFEF00D;
        be[0]      = 4'hF;
        wr[0]      = 1'b1;
        rd[0]      = 1'b1;
        tick();
        wr[0]      = 1'b0;
        rd[0]      = 1'b0;
        stray      = 0;
        for (int i = 0; i < 4; i++) begin
            if (rvalid[0] || wreq[0]) stray++;
            tick();
        end
        compared++;
        if (stray !== 0) begin $display("FAIL rw_no_read: got %0d busy/valid cycles want 0", stray); mismatched++; end
        read_burst(0, 32'h40, 4'd1);
        compared++;
        if (got_data[0] !== 32'hCAFEF00D) begin $display("FAIL rw_write_landed: got %h want cafef00d", got_data[0]); mismatched++; end
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            address[d] = '0; rd[d] = 1'b0; wr[d] = 1'b0; bc[d] = '0; be[d] = '0; wd[d] = '0;
        end
        a3 = '0; rd3 = 1'b0; wr3 = 1'b0; bc3 = '0; be3 = '0; wd3 = '0;
        test_reset();
        test_single();
        test_byte_enables();
        test_incr_burst();
        test_back_to_back();
        test_wrap();
        test_read_write_together();
        test_reset_mid_read();
        test_wide();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
